// File: rtl/instr_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, fills a prefetch FIFO of {pc, instr}
// pairs and hands the head to decode. Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic [31:0]              o_mem_adr,
  input  logic [31:0]              i_mem_instr,
  input  logic                     i_fetch_en,
  input  logic                     i_redirect,
  input  logic [31:0]              i_redirect_pc,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [31:0]              o_instr,
  output logic [31:0]              o_pc,
  output logic [$clog2(DEPTH):0]   o_count
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                     o_misalign
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]    pc;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic [31:0]    fifo_pc    [DEPTH];
  logic [31:0]    fifo_instr [DEPTH];
  logic           full;
  logic           pop;
  logic           push;
  logic           fetch_ok;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      misalign_q <= 1'b0;
    end else if (i_redirect) begin
      misalign_q <= (i_redirect_pc[1:0] != 2'b00);
    end
  end

  assign o_misalign = misalign_q;
  // A trapped target still loads into PC but must never be fetched.
  assign fetch_ok   = ~misalign_q;
`else
  assign fetch_ok   = 1'b1;
`endif

  assign full    = (count == CW'(DEPTH));
  assign o_valid = (count != '0);
  assign pop     = o_valid & i_ready;
  // Popping frees the slot in the same cycle, so a full FIFO can still accept a push.
  assign push    = i_fetch_en & ~i_redirect & fetch_ok & (~full | pop);

  assign o_mem_adr = pc;
  assign o_count   = count;

  always_comb begin
    o_instr = NOP_INSTR;
    o_pc    = '0;
    if (o_valid) begin
      o_instr = fifo_instr[rd_ptr];
      o_pc    = fifo_pc[rd_ptr];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_redirect) begin
      pc     <= i_redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= pc;
      fifo_instr[wr_ptr] <= i_mem_instr;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl (DEPTH=4, RESET_PC=0).
// Memory model returns addr ^ 32'hA5A5_A5A5; define FETCH_MISALIGN_TRAP_EN to test the trap build.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] o_mem_adr;
  logic [31:0] i_mem_instr;
  logic        i_fetch_en;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [2:0]  o_count;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        o_misalign;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_mem_adr    (o_mem_adr),
    .i_mem_instr  (i_mem_instr),
    .i_fetch_en   (i_fetch_en),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .o_count      (o_count)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .o_misalign   (o_misalign)
`endif
  );

  always #5 i_clk = ~i_clk;

  assign i_mem_instr = o_mem_adr ^ KEY;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc_exp, input logic [31:0] cnt_exp);
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    check({tag, "_pc"}, o_pc, pc_exp);
    check({tag, "_instr"}, o_instr, pc_exp ^ KEY);
    check({tag, "_count"}, {29'd0, o_count}, cnt_exp);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    check({tag, "_pc"}, o_pc, 32'd0);
    check({tag, "_instr"}, o_instr, NOP);
    check({tag, "_count"}, {29'd0, o_count}, 32'd0);
  endtask

  initial begin
    i_rst         = 1'b1;
    i_fetch_en    = 1'b1;
    i_ready       = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    #1;
    check_empty("rst");
    check("rst_adr", o_mem_adr, 32'h0);

    @(negedge i_clk);
    i_rst = 1'b0;

    // Streaming at one per cycle, occupancy 1
    step();
    check_head("s0", 32'h0, 32'd1);
    check("s0_adr", o_mem_adr, 32'h4);
    step(); check_head("s1", 32'h4, 32'd1);
    step(); check_head("s2", 32'h8, 32'd1);
    step(); check_head("s3", 32'hC, 32'd1);
    check("s3_adr", o_mem_adr, 32'h10);

    // Stall decode: fill to DEPTH, then hold
    i_ready = 1'b0;
    step(); check("st0_count", {29'd0, o_count}, 32'd2);
    step(); check("st1_count", {29'd0, o_count}, 32'd3);
    step(); check("st2_count", {29'd0, o_count}, 32'd4);
    for (int i = 0; i < 7; i++) begin
      step();
      check("st_hold_count", {29'd0, o_count}, 32'd4);
    end
    check_head("st_head", 32'hC, 32'd4);
    check("st_adr", o_mem_adr, 32'h1C);

    // Full with simultaneous push and pop
    i_ready = 1'b1;
    step();
    check_head("fp", 32'h10, 32'd4);
    check("fp_adr", o_mem_adr, 32'h20);

    // Halt fetch and drain in order
    i_fetch_en = 1'b0;
    step(); check_head("d0", 32'h14, 32'd3);
    step(); check_head("d1", 32'h18, 32'd2);
    step(); check_head("d2", 32'h1C, 32'd1);
    step(); check_empty("d3");
    check("d3_adr", o_mem_adr, 32'h20);
    step(); check_empty("d4");
    check("d4_adr", o_mem_adr, 32'h20);

    // Build count=3 then redirect
    i_fetch_en = 1'b1;
    i_ready    = 1'b0;
    step(); step(); step();
    check_head("pre_rd", 32'h20, 32'd3);
    check("pre_rd_adr", o_mem_adr, 32'h2C);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0100;
    i_ready       = 1'b1;
    step();
    check_empty("rd0");
    check("rd0_adr", o_mem_adr, 32'h100);
    i_redirect = 1'b0;
    step();
    check_head("rd1", 32'h100, 32'd1);

    // Back-to-back redirects: last one wins
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0200;
    step();
    check_empty("bb0");
    i_redirect_pc = 32'h0000_0300;
    step();
    check_empty("bb1");
    check("bb1_adr", o_mem_adr, 32'h300);
    i_redirect = 1'b0;
    step();
    check_head("bb2", 32'h300, 32'd1);

    // PC wrap at top of address space
    i_redirect    = 1'b1;
    i_redirect_pc = 32'hFFFF_FFF8;
    step();
    i_redirect = 1'b0;
    step(); check_head("w0", 32'hFFFF_FFF8, 32'd1);
    step(); check_head("w1", 32'hFFFF_FFFC, 32'd1);
    check("w1_adr", o_mem_adr, 32'h0);
    step(); check_head("w2", 32'h0, 32'd1);

    // Misaligned redirect target
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0102;
    step();
    check("ma0_adr", o_mem_adr, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("ma0_flag", {31'd0, o_misalign}, 32'd1);
    i_redirect = 1'b0;
    step();
    check_empty("ma1");
    check("ma1_flag", {31'd0, o_misalign}, 32'd1);
    check("ma1_adr", o_mem_adr, 32'h102);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0200;
    step();
    check("ma2_flag", {31'd0, o_misalign}, 32'd0);
    i_redirect = 1'b0;
    step();
    check_head("ma3", 32'h200, 32'd1);
`else
    i_redirect = 1'b0;
    step();
    check_head("ma1", 32'h102, 32'd1);
    check("ma1_adr", o_mem_adr, 32'h106);
`endif

    // Asynchronous reset mid-stream with count=3
    i_ready = 1'b0;
    step(); step();
    check("ar_pre_count", {29'd0, o_count}, 32'd3);
    #2;
    i_rst = 1'b1;
    #1;
    check_empty("ar");
    check("ar_adr", o_mem_adr, 32'h0);
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_ready = 1'b1;
    step();
    check_head("ar_restart", 32'h0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
